// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
// Kept separate so the matching receiver can reuse the same encodings.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Zero padding of narrower words leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned             mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_end_o on the last cycle of every CLKS_PER_BIT-cycle period.
// Holding restart_i keeps the count at zero so the next period starts cleanly.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart_i || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable width, parity and stop bits. A one-entry holding
// register in front of the shifter lets the next word start with no idle gap.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 2) begin : g_param_check
        $error("uart_tx_frame: illegal parameter combination");
    end

    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 load;
    logic                 bit_end;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    assign tx_ready = ~hold_full_q & ~rst;
    assign busy     = (state_q != ST_IDLE) | hold_full_q;
    assign uart_tx  = tx_q;
    assign tx_done  = done_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        load        = 1'b0;

        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LastData) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LastStop) begin
                        done_d = 1'b1;
                        // A queued word starts immediately, with no idle-high cycle.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = ST_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            par_d       = parity_bit(MAX_DATA_BITS'(hold_q), PARITY);
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: an 8N1 transmitter plus 7E2 and 7O2 variants, all at 4 clocks per bit.
// Expected line waveforms are hand-built frame bit vectors, LSB-first, one bit per 4 cycles.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data8;
    logic       tx_valid8;
    logic       ready8, tx8, busy8, done8;
    logic [6:0] tx_data7;
    logic       tx_valid7;
    logic       ready_e, tx_e, busy_e, done_e;
    logic       ready_o, tx_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;

    uart_tx_frame #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8),
        .PARITY       (0),
        .STOP_BITS    (1)
    ) dut8 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data8),
        .tx_valid (tx_valid8),
        .tx_ready (ready8),
        .uart_tx  (tx8),
        .busy     (busy8),
        .tx_done  (done8)
    );

    uart_tx_frame #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (7),
        .PARITY       (1),
        .STOP_BITS    (2)
    ) dut7e (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data7),
        .tx_valid (tx_valid7),
        .tx_ready (ready_e),
        .uart_tx  (tx_e),
        .busy     (busy_e),
        .tx_done  (done_e)
    );

    uart_tx_frame #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (7),
        .PARITY       (2),
        .STOP_BITS    (2)
    ) dut7o (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data7),
        .tx_valid (tx_valid7),
        .tx_ready (ready_o),
        .uart_tx  (tx_o),
        .busy     (busy_o),
        .tx_done  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Handshake one word into the 8N1 instance; returns just after E0.
    task automatic send8(input logic [7:0] data);
        tx_data8  = data;
        tx_valid8 = 1'b1;
        tick();
        tx_valid8 = 1'b0;
        chk("send8_ready", 0, ready8, 1'b0);
        chk("send8_busy", 0, busy8, 1'b1);
        chk("send8_idle_line", 0, tx8, 1'b1);
    endtask

    // Check the 8N1 line for cycles kfirst..klast after E0; bits[i] is serial bit i.
    task automatic watch8(input string tag, input logic [19:0] bits, input int kfirst,
                          input int klast, input logic jam);
        logic exp_tx;
        for (int k = kfirst; k <= klast; k++) begin
            tick();
            exp_tx = (((k - 1) / 4) < 20) ? bits[(k-1)/4] : 1'b1;
            chk({tag, "_line"}, k, tx8, exp_tx);
            chk({tag, "_done"}, k, done8, (k > 1) && (((k - 1) % 40) == 0));
            chk({tag, "_busy"}, k, busy8, k < klast);
            if (jam) begin
                if (k < 41) begin
                    chk({tag, "_ready_jam"}, k, ready8, 1'b0);
                    tx_data8 = 8'(k * 37 + 5);
                end else if (k == 41) begin
                    tx_valid8 = 1'b0;
                end
            end
        end
    endtask

    // Two words with tx_valid held; the second is accepted at E2 once the first drains.
    task automatic pair8(input string tag, input logic [7:0] first, input logic [7:0] second,
                         input logic [19:0] bits, input logic jam);
        tx_data8  = first;
        tx_valid8 = 1'b1;
        tick();
        tx_data8 = second;
        chk({tag, "_ready_e0"}, 0, ready8, 1'b0);
        tick();
        chk({tag, "_start_e1"}, 1, tx8, 1'b0);
        chk({tag, "_ready_e1"}, 1, ready8, 1'b1);
        tick();
        if (!jam) tx_valid8 = 1'b0;
        chk({tag, "_ready_e2"}, 2, ready8, 1'b0);
        chk({tag, "_busy_e2"}, 2, busy8, 1'b1);
        watch8(tag, bits, 3, 81, jam);
    endtask

    initial begin
        int txlow;
        int dones;
        logic [10:0] be;
        logic [10:0] bo;

        rst       = 1'b1;
        tx_data8  = '0;
        tx_valid8 = 1'b0;
        tx_data7  = '0;
        tx_valid7 = 1'b0;

        // Reset held for three edges.
        tick();
        tick();
        tick();
        chk("rst_line", 0, tx8, 1'b1);
        chk("rst_busy", 0, busy8, 1'b0);
        chk("rst_done", 0, done8, 1'b0);
        chk("rst_ready", 0, ready8, 1'b0);
        chk("rst_ready7", 0, {ready_e, ready_o}, 2'b00);
        rst = 1'b0;
        #1;
        chk("rel_ready", 0, ready8, 1'b1);
        chk("rel_ready7", 0, {ready_e, ready_o}, 2'b11);
        tick();

        // 8N1 0xA5: 0 | 1 0 1 0 0 1 0 1 | 1
        send8(8'hA5);
        watch8("a5", {10'h3FF, 10'b1101001010}, 1, 41, 1'b0);

        // Back-to-back 0x00 then 0xFF, no idle between frames.
        pair8("b2b", 8'h00, 8'hFF, {10'b1111111110, 10'b1000000000}, 1'b0);

        // Valid held with toggling data while the holding register is full.
        pair8("jam", 8'h5A, 8'hC3, {10'b1110000110, 10'b1010110100}, 1'b1);
        tick();
        chk("jam_no_third", 0, busy8, 1'b0);

        // 7E2 / 7O2 with data 0x07: parity 1 (even) or 0 (odd), 44-cycle frames.
        be = 11'b11100001110;
        bo = 11'b11000001110;
        tx_data7  = 7'h07;
        tx_valid7 = 1'b1;
        tick();
        tx_valid7 = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            chk("p_even_line", k, tx_e, (((k - 1) / 4) < 11) ? be[(k-1)/4] : 1'b1);
            chk("p_odd_line", k, tx_o, (((k - 1) / 4) < 11) ? bo[(k-1)/4] : 1'b1);
            chk("p_done", k, {done_e, done_o}, (k == 45) ? 2'b11 : 2'b00);
            chk("p_busy", k, {busy_e, busy_o}, (k < 45) ? 2'b11 : 2'b00);
        end

        // Reset during data bit 3 of 0x3C with 0x99 queued.
        tx_data8  = 8'h3C;
        tx_valid8 = 1'b1;
        tick();
        tx_data8 = 8'h99;
        tick();
        tick();
        tx_valid8 = 1'b0;
        for (int k = 3; k <= 18; k++) tick();
        chk("abort_bit3", 18, tx8, 1'b1);
        chk("abort_queued", 18, ready8, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort_line", 19, tx8, 1'b1);
        chk("abort_busy", 19, busy8, 1'b0);
        chk("abort_done", 19, done8, 1'b0);
        chk("abort_ready", 19, ready8, 1'b0);
        rst   = 1'b0;
        txlow = 0;
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (tx8 !== 1'b1) txlow++;
            if (done8 !== 1'b0) dones++;
        end
        chk("abort_quiet_line", 0, txlow, 0);
        chk("abort_no_done", 0, dones, 0);
        chk("abort_idle", 0, busy8, 1'b0);

        // 0x81 after the abort: 0 | 1 0 0 0 0 0 0 1 | 1
        send8(8'h81);
        watch8("x81", {10'h3FF, 10'b1100000010}, 1, 41, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
